// File: rtl/ser_multicast_router.sv
// ser_multicast_router
//
// Receives self-describing serial frames on serIn and fans the payload out
// to one line in each enabled group of the W[] array.
//
// Frame on serIn (line idles high), in arrival order:
//   start bit 0 | GROUPS mask bits (PB[0] first) | LB_W index bits (LB[0] first)
//   | PAYLOAD_LEN payload bits (LSB first)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (aborts any frame in flight)
//   serIn  in   serial frame input
//   W      out  [0:GROUPS*LINES-1] retimed payload, index = g*LINES + lb
//   busy   out  high while in HEADER or PAYLOAD
//   valid  out  high in each cycle W carries a payload bit
//   done   out  one-cycle pulse together with the last payload bit on W
//   err    out  one-cycle pulse in the first payload cycle of a frame whose
//               group mask is all zero
//
// Output timing: the payload bit sampled on edge k is visible on W, valid
// and done from edge k+1 onwards for one cycle. Everything but busy is a
// flop output; busy is decoded straight from the state register.

module ser_multicast_router #(
    parameter int GROUPS      = 4,
    parameter int LINES       = 4,
    parameter int PAYLOAD_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serIn,
    output logic [0:GROUPS*LINES-1]   W,
    output logic                      busy,
    output logic                      valid,
    output logic                      done,
    output logic                      err
);

    localparam int LB_W    = $clog2(LINES);
    localparam int HDR_LEN = GROUPS + LB_W;
    localparam int CNT_MAX = (HDR_LEN > PAYLOAD_LEN) ? HDR_LEN : PAYLOAD_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int NW      = GROUPS * LINES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [GROUPS-1:0]   pb_q,    pb_d;
    logic [LB_W-1:0]     lb_q,    lb_d;
    logic [0:NW-1]       w_q,     w_d;
    logic                valid_q, valid_d;
    logic                done_q,  done_d;
    logic                err_q,   err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pb_d    = pb_q;
        lb_d    = lb_q;
        w_d     = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!serIn) begin
                    state_d = ST_HEADER;
                    cnt_d   = '0;
                end
            end

            ST_HEADER: begin
                // Mask bits occupy header slots 0..GROUPS-1, index bits follow.
                for (int g = 0; g < GROUPS; g++) begin
                    if (cnt_q == CNT_W'(g)) pb_d[g] = serIn;
                end
                for (int b = 0; b < LB_W; b++) begin
                    if (cnt_q == CNT_W'(GROUPS + b)) lb_d[b] = serIn;
                end

                if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    // The last header bit is an index bit, so pb_q already
                    // holds the complete mask here.
                    err_d   = (pb_q == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PAYLOAD: begin
                for (int g = 0; g < GROUPS; g++) begin
                    for (int l = 0; l < LINES; l++) begin
                        if (pb_q[g] && (lb_q == LB_W'(l))) begin
                            w_d[g*LINES + l] = serIn;
                        end
                    end
                end
                // An empty mask still consumes the payload, but never
                // claims to carry data.
                valid_d = (pb_q != '0);

                if (cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
                    // Back to IDLE now so the cycle that shows the last bit
                    // can already sample the next start bit.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pb_q    <= '0;
            lb_q    <= '0;
            w_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pb_q    <= pb_d;
            lb_q    <= lb_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign W     = w_q;
    assign busy  = (state_q != ST_IDLE);
    assign valid = valid_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ser_multicast_router.sv
// Bench for ser_multicast_router (GROUPS=4, LINES=4, PAYLOAD_LEN=8).
// Inputs change on the falling edge; outputs are checked on the falling edge
// just before the next input change, i.e. half a cycle after the DUT edge.

module tb_ser_multicast_router;

    localparam int GROUPS      = 4;
    localparam int LINES       = 4;
    localparam int PAYLOAD_LEN = 8;
    localparam int NW          = GROUPS * LINES;

    logic            clk;
    logic            rst;
    logic            serIn;
    logic [0:NW-1]   w;
    logic            busy;
    logic            valid;
    logic            done;
    logic            err;

    int checks;
    int errors;

    ser_multicast_router #(
        .GROUPS      (GROUPS),
        .LINES       (LINES),
        .PAYLOAD_LEN (PAYLOAD_LEN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .serIn (serIn),
        .W     (w),
        .busy  (busy),
        .valid (valid),
        .done  (done),
        .err   (err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    // exp_mask lists, by hand, the W lines that must carry the payload.
    typedef struct {
        logic [3:0]    pb;
        logic [1:0]    lb;
        logic [7:0]    payload;
        logic [0:15]   exp_mask;
        bit            b2b;       // next frame starts in this frame's done cycle
    } vec_t;

    vec_t vecs[6];

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts driving at a falling edge with the start bit; returns at the
    // falling edge of the done cycle, after checking it, with serIn untouched.
    task automatic run_frame(input vec_t v);
        logic [0:15] exp_w;
        bit          b;
        serIn = 1'b0;
        for (int i = 0; i < GROUPS; i++) begin
            @(negedge clk);
            chk("hdr_busy", {31'd0, busy}, 32'd1);
            chk("hdr_w", {16'd0, w}, 32'd0);
            serIn = v.pb[i];
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hdr_busy", {31'd0, busy}, 32'd1);
            serIn = v.lb[i];
        end
        // First payload cycle: err reflects the mask, nothing on W yet.
        @(negedge clk);
        chk("pay0_err", {31'd0, err}, {31'd0, (v.exp_mask == 16'd0)});
        chk("pay0_w", {16'd0, w}, 32'd0);
        chk("pay0_valid", {31'd0, valid}, 32'd0);
        serIn = v.payload[0];
        for (int k = 0; k < PAYLOAD_LEN; k++) begin
            @(negedge clk);
            b     = v.payload[k];
            exp_w = b ? v.exp_mask : 16'd0;
            chk("pay_w", {16'd0, w}, {16'd0, exp_w});
            chk("pay_valid", {31'd0, valid}, {31'd0, (v.exp_mask != 16'd0)});
            chk("pay_done", {31'd0, done}, {31'd0, (k == PAYLOAD_LEN - 1)});
            chk("pay_err", {31'd0, err}, 32'd0);
            chk("pay_busy", {31'd0, busy}, {31'd0, (k != PAYLOAD_LEN - 1)});
            if (k < PAYLOAD_LEN - 1) serIn = v.payload[k+1];
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk({name, "_w"}, {16'd0, w}, 32'd0);
        chk({name, "_flags"}, {28'd0, busy, valid, done, err}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{pb: 4'b0101, lb: 2'd2, payload: 8'hA5, exp_mask: 16'b0010_0000_0010_0000, b2b: 1'b0};
        vecs[1] = '{pb: 4'b1111, lb: 2'd3, payload: 8'hFF, exp_mask: 16'b0001_0001_0001_0001, b2b: 1'b0};
        vecs[2] = '{pb: 4'b0000, lb: 2'd0, payload: 8'hFF, exp_mask: 16'b0000_0000_0000_0000, b2b: 1'b0};
        vecs[3] = '{pb: 4'b0001, lb: 2'd1, payload: 8'h96, exp_mask: 16'b0100_0000_0000_0000, b2b: 1'b1};
        vecs[4] = '{pb: 4'b1000, lb: 2'd0, payload: 8'h6B, exp_mask: 16'b0000_0000_0000_1000, b2b: 1'b0};
        vecs[5] = '{pb: 4'b0110, lb: 2'd1, payload: 8'h81, exp_mask: 16'b0000_0100_0100_0000, b2b: 1'b0};

        // Reset and idle.
        serIn = 1'b1;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_w", {16'd0, w}, 32'd0);
        chk("reset_flags", {28'd0, busy, valid, done, err}, 32'd0);
        rst = 1'b0;
        repeat (2) idle_check("idle");

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
            if (!vecs[i].b2b) begin
                serIn = 1'b1;
                idle_check("post_frame");
            end
        end

        // Reset during the 4th payload bit: outputs must clear without a clock edge.
        begin
            vec_t v;
            v = '{pb: 4'b1111, lb: 2'd1, payload: 8'hFF, exp_mask: 16'b0100_0100_0100_0100, b2b: 1'b0};
            serIn = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                serIn = (i < 4) ? v.pb[i] : v.lb[i-4];
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                serIn = v.payload[k];
            end
            // Third bit is on W now; the 4th bit is being presented.
            chk("pre_rst_w", {16'd0, w}, {16'd0, v.exp_mask});
            #2 rst = 1'b1;
            #1;
            chk("async_rst_w", {16'd0, w}, 32'd0);
            chk("async_rst_flags", {28'd0, busy, valid, done, err}, 32'd0);
            @(negedge clk);
            rst   = 1'b0;
            serIn = 1'b1;
            idle_check("post_rst");
            // A new frame after the abort routes only to W[4].
            v = '{pb: 4'b0010, lb: 2'd0, payload: 8'h3C, exp_mask: 16'b0000_1000_0000_0000, b2b: 1'b0};
            run_frame(v);
            serIn = 1'b1;
            idle_check("post_rst_frame");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_multicast_router.md
Name: ser_multicast_router

Overview:
- Framed successor to the combinational serial multibroadcaster.
- Accepts self-describing serial frames on serIn. Each frame is a start bit, a group mask, a line index, and a fixed-length payload.
- Every payload bit is retimed and driven onto the selected line of every enabled group in the W[] fan-out. All other lines stay 0.
- Sits between a single serial source and GROUPS×LINES downstream serial sinks. It replaces static PB/LB select inputs with in-band addressing.

Parameters:
- GROUPS, 4, number of line groups; width of the in-band group mask PB.
- LINES, 4, lines per group; power of two, ≥2.
- PAYLOAD_LEN, 8, payload bits per frame; ≥1.
- (local) LB_W = clog2(LINES), line-index width. CNT_W = clog2(max(GROUPS+LB_W, PAYLOAD_LEN)+1), bit counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- serIn  input  1  serial frame input; line idles high.
- W  output  [0:GROUPS*LINES-1]  retimed payload fan-out. Index = g*LINES + lb.
- busy  output  1  high while a frame is being received (HEADER or PAYLOAD).
- valid  output  1  high in each cycle W carries a payload bit.
- done  output  1  one-cycle pulse coincident with the last payload bit on W.
- err  output  1  one-cycle pulse when a frame's group mask is all zero.

Behaviour:
- Reset: state=IDLE. W, busy, valid, done, err, PB/LB registers and counter all =0. Reset asserted mid-frame aborts the frame immediately; a partial payload is never resumed.
- All decisions use serIn sampled on the rising clk edge.
- Frame format, in serIn order:
  - start bit 0;
  - GROUPS mask bits, PB[0] first;
  - LB_W index bits, LB[0] first;
  - PAYLOAD_LEN payload bits, LSB first.
- IDLE:
  - serIn=0 → HEADER, counter cleared.
  - serIn=1 → stay in IDLE.
  - W=0, busy=0.
- HEADER:
  - Shift in PB, then LB, for GROUPS+LB_W cycles; busy=1.
  - On the last header bit → PAYLOAD, counter cleared.
  - If the assembled PB==0, pulse err in the first PAYLOAD cycle.
- PAYLOAD:
  - PAYLOAD_LEN cycles; busy=1.
  - Bit sampled in cycle k appears at cycle k+1 (1-cycle latency) on W[g*LINES+LB] for every g with PB[g]=1, with valid=1. All other W bits =0.
  - PB==0: frame is still consumed for its full length, valid=0, W stays 0, done still pulses.
- Completion:
  - After the last payload sample, state returns to IDLE.
  - The following cycle shows the last bit on W with valid=1 and done=1.
  - In that same cycle serIn is sampled as a possible start bit, so back-to-back frames have zero idle gap.
- W is fully registered (no combinational path from serIn). W returns to 0 the cycle after the last payload bit unless a new payload bit is being output.
- PB/LB are held constant for the whole payload. They update only in HEADER.
- A serIn glitch low in IDLE is indistinguishable from a start bit; framing integrity is the source's responsibility.

Test Plan:
- Defaults; idle high, rst pulse mid-stream → W=0, busy=valid=done=err=0 immediately (async, no clk edge needed).
- Frame: 0; PB bits 1,0,1,0 (PB=4'b0101); LB bits 0,1 (LB=2); payload 8'hA5 LSB first → W[2] and W[10] carry 1,0,1,0,0,1,0,1 with 1-cycle latency, valid=1 for exactly 8 cycles, all other W=0, done pulses with the 8th bit.
- PB=4'b1111, LB=3, payload 8'hFF → W[3],W[7],W[11],W[15] high for 8 cycles; remaining 12 lines stay 0.
- PB=4'b0000, LB=0, payload 8'hFF → err pulse once, W stays 0, valid=0, done still pulses 8 cycles after the first payload sample.
- Two frames back-to-back (second start bit in the done cycle), PB=0001/LB=1 then PB=1000/LB=0 → W[1] then W[12] streams, no lost bit, no overlap.
- rst asserted during the 4th payload bit of an active frame, released, then a new frame with PB=0010/LB=0/8'h3C → W clears at once, and the new frame routes 8'h3C only to W[4].
